// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM req/ack handshake and the IF/ID register.
// Honours ctrl stall/flush and ID branch redirects with a single MIPS delay slot.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] target_reg, target_d;
    logic [31:0] buf_pc, buf_pc_d, buf_inst, buf_inst_d;
    logic [31:0] id_pc_d, id_inst_d;
    logic        id_valid_d, rom_req_d;
    logic        pending, pending_d;
    logic        slot_done, slot_done_d;
    logic        take_branch, delivered;
    logic [31:0] eff_target, next_pc;

    assign rom_addr_o = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            target_reg <= '0;
            buf_pc     <= '0;
            buf_inst   <= '0;
            pending    <= 1'b0;
            slot_done  <= 1'b0;
            rom_req_o  <= 1'b0;
            id_pc_o    <= '0;
            id_inst_o  <= '0;
            id_valid_o <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            target_reg <= target_d;
            buf_pc     <= buf_pc_d;
            buf_inst   <= buf_inst_d;
            pending    <= pending_d;
            slot_done  <= slot_done_d;
            rom_req_o  <= rom_req_d;
            id_pc_o    <= id_pc_d;
            id_inst_o  <= id_inst_d;
            id_valid_o <= id_valid_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        target_d    = target_reg;
        buf_pc_d    = buf_pc;
        buf_inst_d  = buf_inst;
        pending_d   = pending;
        slot_done_d = slot_done;
        id_pc_d     = id_pc_o;
        id_inst_d   = id_inst_o;
        id_valid_d  = id_valid_o;
        delivered   = 1'b0;
        take_branch = branch_flag_i && !stall;
        // a branch arriving this cycle supersedes any older pending target
        eff_target  = take_branch ? branch_target_i : target_reg;
        next_pc     = pending ? eff_target : pc + 32'(PC_INC);

        if (flush) begin
            state_d     = FETCH;
            pc_d        = new_pc;
            buf_pc_d    = '0;
            buf_inst_d  = '0;
            pending_d   = 1'b0;
            slot_done_d = 1'b0;
            id_pc_d     = '0;
            id_inst_d   = '0;
            id_valid_d  = 1'b0;
        end else begin
            case (state)
                IDLE: state_d = FETCH;
                FETCH: begin
                    // delay slot already delivered: abandon the sequential fetch, jump to target
                    if (pending && slot_done) begin
                        if (!stall) begin
                            pc_d        = eff_target;
                            pending_d   = 1'b0;
                            slot_done_d = 1'b0;
                            id_valid_d  = 1'b0;
                            id_inst_d   = '0;
                        end
                    end else if (rom_ack_i) begin
                        pc_d        = next_pc;
                        pending_d   = 1'b0;
                        slot_done_d = 1'b0;
                        if (stall) begin
                            buf_pc_d   = pc;
                            buf_inst_d = rom_data_i;
                            state_d    = HOLD;
                        end else begin
                            id_pc_d    = pc;
                            id_inst_d  = rom_data_i;
                            id_valid_d = 1'b1;
                            delivered  = 1'b1;
                        end
                    end else if (!stall) begin
                        id_valid_d = 1'b0;
                        id_inst_d  = '0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_pc_d    = buf_pc;
                        id_inst_d  = buf_inst;
                        id_valid_d = 1'b1;
                        state_d    = FETCH;
                        delivered  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (take_branch && state != IDLE) begin
                if (delivered && !pending) begin
                    target_d    = branch_target_i;
                    pending_d   = 1'b1;
                    slot_done_d = 1'b1;
                end else if (!delivered && !(pending && slot_done)) begin
                    target_d  = branch_target_i;
                    pending_d = 1'b1;
                end
            end
        end

        rom_req_d = (state_d == FETCH) && !(pending_d && slot_done_d);
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: stimulus pushes expected IF/ID deliveries,
// a negedge monitor pops and compares each new delivery; directed checks cover addresses/flags.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall, flush, branch_flag_i, ack_en;
    logic [31:0] new_pc, branch_target_i;
    logic        rom_req_o, rom_ack_i;
    logic [31:0] rom_addr_o, rom_data_i;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_valid_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [63:0] exp_q[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i),
        .rom_data_i(rom_data_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .id_valid_o(id_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] romw(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign rom_ack_i  = rom_req_o & ack_en;
    assign rom_data_i = romw(rom_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_q.push_back({a, romw(a)});
    endtask

    // monitor: a new delivery is a valid IF/ID whose pc differs from the last one seen
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = '0;
    always @(negedge clk) begin
        if (rst && id_valid_o && (!prev_valid || id_pc_o != prev_pc)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_delivery: got pc %h inst %h expected none", id_pc_o, id_inst_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({id_pc_o, id_inst_o} !== e) begin
                    n_fail++;
                    $display("FAIL delivery: got pc %h inst %h expected pc %h inst %h",
                             id_pc_o, id_inst_o, e[63:32], e[31:0]);
                end
            end
        end
        prev_valid = rst && id_valid_o;
        prev_pc    = id_pc_o;
    end

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag_i = 1'b0;
        new_pc = '0; branch_target_i = '0; ack_en = 1'b1;
        tick(); tick();
        check("rst_req", {31'd0, rom_req_o}, 32'd0);
        check("rst_addr", rom_addr_o, 32'h0);
        check("rst_valid", {31'd0, id_valid_o}, 32'd0);
        check("rst_inst", id_inst_o, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);

        // 1: release, ack every cycle
        rst = 1'b1;
        check("idle_req", {31'd0, rom_req_o}, 32'd0);
        expect_word(32'h0); expect_word(32'h4); expect_word(32'h8); expect_word(32'hC);
        expect_word(32'h10); expect_word(32'h14);
        tick();                                   // E1
        check("t1_addr0", rom_addr_o, 32'h0);
        check("t1_req", {31'd0, rom_req_o}, 32'd1);
        tick();                                   // E2
        check("t1_addr4", rom_addr_o, 32'h4);
        check("t1_valid", {31'd0, id_valid_o}, 32'd1);
        check("t1_idpc0", id_pc_o, 32'h0);
        tick();                                   // E3
        check("t1_addr8", rom_addr_o, 32'h8);
        check("t1_idpc4", id_pc_o, 32'h4);

        // 2: ack delayed two cycles at pc=8
        ack_en = 1'b0;
        tick();                                   // E4
        check("t2_addr_hold1", rom_addr_o, 32'h8);
        check("t2_bubble1", {31'd0, id_valid_o}, 32'd0);
        check("t2_bubble_inst", id_inst_o, 32'h0);
        tick();                                   // E5
        check("t2_addr_hold2", rom_addr_o, 32'h8);
        check("t2_bubble2", {31'd0, id_valid_o}, 32'd0);
        ack_en = 1'b1;
        tick();                                   // E6
        check("t2_valid8", {31'd0, id_valid_o}, 32'd1);
        check("t2_idpc8", id_pc_o, 32'h8);
        tick();                                   // E7
        check("t2_addr10", rom_addr_o, 32'h10);

        // 3: stall three cycles while 0x10 is acked
        stall = 1'b1;
        tick();                                   // E8
        check("t3_hold_req", {31'd0, rom_req_o}, 32'd0);
        check("t3_hold_idpc", id_pc_o, 32'hC);
        tick();                                   // E9
        check("t3_hold_req2", {31'd0, rom_req_o}, 32'd0);
        check("t3_hold_inst", id_inst_o, romw(32'hC));
        tick();                                   // E10
        check("t3_hold_idpc3", id_pc_o, 32'hC);
        stall = 1'b0;
        tick();                                   // E11
        check("t3_release_idpc", id_pc_o, 32'h10);
        check("t3_resume_addr", rom_addr_o, 32'h14);
        check("t3_resume_req", {31'd0, rom_req_o}, 32'd1);

        // 4: branch to 0x100 while 0x20 is accepted
        expect_word(32'h18); expect_word(32'h1C); expect_word(32'h20); expect_word(32'h100);
        tick();                                   // E12
        tick();                                   // E13
        tick();                                   // E14
        check("t4_addr20", rom_addr_o, 32'h20);
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        tick();                                   // E15
        branch_flag_i = 1'b0; branch_target_i = '0;
        check("t4_slot_idpc", id_pc_o, 32'h20);
        check("t4_no_req_24", {31'd0, rom_req_o}, 32'd0);
        tick();                                   // E16
        check("t4_target_addr", rom_addr_o, 32'h100);
        check("t4_no_24", {31'd0, id_valid_o}, 32'd0);
        tick();                                   // E17
        check("t4_idpc100", id_pc_o, 32'h100);
        check("t4_addr104", rom_addr_o, 32'h104);

        // 5: pending branch then flush with stall and ack
        ack_en = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        tick();                                   // E18
        branch_flag_i = 1'b0; branch_target_i = '0;
        flush = 1'b1; new_pc = 32'h180; stall = 1'b1; ack_en = 1'b1;
        tick();                                   // E19
        flush = 1'b0; new_pc = '0; stall = 1'b0;
        check("t5_valid", {31'd0, id_valid_o}, 32'd0);
        check("t5_inst", id_inst_o, 32'h0);
        check("t5_idpc", id_pc_o, 32'h0);
        check("t5_addr", rom_addr_o, 32'h180);
        expect_word(32'h180);
        tick();                                   // E20
        check("t5_no_stale_branch", rom_addr_o, 32'h184);

        // 6: wrap at top of address space, then async reset
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();                                   // E21
        flush = 1'b0; new_pc = '0;
        check("t6_addr_top", rom_addr_o, 32'hFFFF_FFFC);
        expect_word(32'hFFFF_FFFC);
        tick();                                   // E22
        ack_en = 1'b0;
        check("t6_wrap", rom_addr_o, 32'h0);
        check("t6_top_valid", {31'd0, id_valid_o}, 32'd1);
        #6;
        rst = 1'b0;
        #1;
        check("t6_async_req", {31'd0, rom_req_o}, 32'd0);
        check("t6_async_valid", {31'd0, id_valid_o}, 32'd0);
        check("t6_async_inst", id_inst_o, 32'h0);
        check("t6_async_pc", id_pc_o, 32'h0);
        check("t6_async_addr", rom_addr_o, 32'h0);
        tick(); tick();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
